// File: rtl/mmio_uart_tx_pkg.sv
// Shared MMIO map for the UART transmitter: register offsets, status bit
// positions and the baud divisor helper.
package mmio_uart_tx_pkg;

  localparam logic [31:0] UART_BASE_DEF   = 32'h2000_0000;
  localparam logic [31:0] UART_STATUS_OFS = 32'd4;

  // Status word layout: {16'b0, count[7:0], 5'b0, tx_active, empty, full}
  localparam int STAT_FULL_BIT   = 0;
  localparam int STAT_EMPTY_BIT  = 1;
  localparam int STAT_ACTIVE_BIT = 2;
  localparam int STAT_COUNT_LSB  = 8;

  // Cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty/count; head entry is readable
// combinationally. Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Next occupancy; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (do_push & ~do_pop)      count_d = count_q + 1'b1;
    else if (do_pop & ~do_push) count_d = count_q - 1'b1;
  end

  // Storage has no reset; only the pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers, count and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store decode, back-pressure stall,
// status register, baud counter and TX state machine around a byte FIFO.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] UART_BASE  = UART_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        uart_txd,
  output logic        tx_busy
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q;
  logic [31:0]      rdata_q;

  logic          hit_data, hit_stat, push, pop, bit_end, empty_nxt;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic [23:0]   unused_wdata;

  assign unused_wdata = wdata[31:8];

  assign hit_data = (addr == UART_BASE);
  assign hit_stat = (addr == UART_BASE + UART_STATUS_OFS);
  assign push     = mem_write & hit_data & ~fifo_full;
  // Registered full: a pop this cycle does not release the store until next cycle.
  assign stall    = mem_write & hit_data & fifo_full;
  assign bit_end  = (cnt_q == '0);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // TX next-state: each bit holds for DIV cycles; STOP chains straight into
  // the next START when a byte is waiting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop = 1'b1; shift_d = fifo_head; txd_d = 1'b0;
          cnt_d = RELOAD; state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          txd_d = shift_q[0]; bit_d = 3'd0; cnt_d = RELOAD; state_d = DATA;
        end else cnt_d = cnt_q - 1'b1;
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = RELOAD;
          if (bit_q == 3'd7) begin
            txd_d = 1'b1; state_d = STOP;
          end else begin
            shift_d = shift_q >> 1; txd_d = shift_q[1]; bit_d = bit_q + 3'd1;
          end
        end else cnt_d = cnt_q - 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop = 1'b1; shift_d = fifo_head; txd_d = 1'b0;
            cnt_d = RELOAD; state_d = START;
          end else state_d = IDLE;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO empty after this edge, for the registered busy flag.
  assign empty_nxt = (fifo_empty & ~push) |
                     ((fifo_count == CW'(1)) & pop & ~push);

  // TX state, line and busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= (state_d != IDLE) | ~empty_nxt;
    end
  end

  // Status word assembled from the current (pre-edge) state.
  always_comb begin
    status = '0;
    status[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
    status[STAT_ACTIVE_BIT]     = (state_q != IDLE);
    status[STAT_EMPTY_BIT]      = fifo_empty;
    status[STAT_FULL_BIT]       = fifo_full;
  end

  // Load data: status at BASE+4, zero at BASE, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst)                       rdata_q <= '0;
    else if (mem_read && hit_stat) rdata_q <= status;
    else if (mem_read && hit_data) rdata_q <= '0;
  end

  assign rdata    = rdata_q;
  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;

endmodule
